iccm_port_arbiter: RTL and testbench

//  Sits directly downstream of the UART programmer. Consumes its write stream (we/addr/wdata)
//  and its busy/reset flag, and owns the single ICCM SRAM port. Grants the port to the programmer

---
 rtl/iccm_arb_pkg.sv | 21 ++
 rtl/prog_release_timer.sv | 34 +++
 rtl/iccm_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_iccm_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : iccm_arb_pkg
// Brief    : Shared widths, timer sizing and FSM encoding for the ICCM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package iccm_arb_pkg;

    localparam int unsigned c_ADDR_W         = 12;
    localparam int unsigned c_DATA_W         = 32;
    localparam int unsigned c_RELEASE_CYCLES = 16;
    localparam int unsigned c_TIMER_W        = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/prog_release_timer.sv
`default_nettype none
// ============================================================================
// Module   : prog_release_timer
// Brief    : Loadable down-counter with zero flag; stops at zero.
// Revision : 1.0 - initial release
// ============================================================================
module prog_release_timer #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= RST_VAL;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero_o = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/iccm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iccm_port_arbiter
// Brief    : Owns the ICCM SRAM port; programmer writes during LOAD, core
//            fetches during RUN, core held in reset through LOAD and RELEASE.
// Revision : 1.0 - initial release
// ============================================================================
module iccm_port_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = c_ADDR_W,
    parameter int unsigned DATA_W         = c_DATA_W,
    parameter int unsigned RELEASE_CYCLES = c_RELEASE_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_wdata_i,
    input  logic              prog_reset_i,
    input  logic              core_req_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_rst_o,
    output logic              iccm_csb_o,
    output logic              iccm_web_o,
    output logic [ADDR_W-1:0] iccm_addr_o,
    output logic [DATA_W-1:0] iccm_wdata_o,
    input  logic [DATA_W-1:0] iccm_rdata_i,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic [DATA_W-1:0] checksum_o,
    output logic              ign_wr_o
);

    localparam logic [c_TIMER_W-1:0] c_REL_LOAD = c_TIMER_W'(RELEASE_CYCLES - 1);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic              w_timer_zero;
    logic              w_timer_load;
    logic              w_timer_dec;
    logic              w_load_entry;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_stray_wr;

    logic              r_core_rst;
    logic              r_csb;
    logic              r_web;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd_pend;
    logic              r_rvalid;
    logic [ADDR_W:0]   r_word_cnt;
    logic [DATA_W-1:0] r_checksum;
    logic              r_ign_wr;

    prog_release_timer #(
        .WIDTH   (c_TIMER_W),
        .RST_VAL (c_REL_LOAD)
    ) u_release_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_timer_load),
        .load_val_i (c_REL_LOAD),
        .dec_i      (w_timer_dec),
        .zero_o     (w_timer_zero)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RELEASE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (prog_reset_i) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (!prog_reset_i) w_next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A restarted load takes priority over an expiring window
                if (prog_reset_i)      w_next_state = ST_LOAD;
                else if (w_timer_zero) w_next_state = ST_RUN;
            end
            default: w_next_state = ST_RELEASE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        w_load_entry = (w_next_state == ST_LOAD) && (r_state != ST_LOAD);
        w_timer_load = (r_state == ST_LOAD) && (w_next_state == ST_RELEASE);
        w_timer_dec  = (r_state == ST_RELEASE) && !prog_reset_i;
        w_wr_fire    = (r_state == ST_LOAD) && prog_we_i;
        w_rd_fire    = (r_state == ST_RUN) && core_req_i;
        w_stray_wr   = (r_state != ST_LOAD) && prog_we_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_core_rst <= 1'b1;
        end else begin
            r_core_rst <= (w_next_state != ST_RUN);
        end
    end

    // SRAM port: writes only in LOAD, reads only in RUN, so they never overlap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_wr_fire) begin
            r_csb   <= 1'b0;
            r_web   <= 1'b0;
            r_addr  <= prog_addr_i;
            r_wdata <= prog_wdata_i;
        end else if (w_rd_fire) begin
            r_csb   <= 1'b0;
            r_web   <= 1'b1;
            r_addr  <= core_addr_i;
        end else begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_pend <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_fire;
            r_rvalid  <= r_rd_pend;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word_cnt <= '0;
            r_checksum <= '0;
        end else if (w_load_entry) begin
            r_word_cnt <= '0;
            r_checksum <= '0;
        end else if (w_wr_fire) begin
            if (!r_word_cnt[ADDR_W]) r_word_cnt <= r_word_cnt + 1'b1;
            r_checksum <= r_checksum + prog_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ign_wr <= 1'b0;
        end else if (w_stray_wr) begin
            r_ign_wr <= 1'b1;
        end
    end

    assign core_gnt_o    = w_rd_fire;
    assign core_rvalid_o = r_rvalid;
    // SRAM data arrives the cycle after the read is presented, aligned with r_rvalid
    assign core_rdata_o  = r_rvalid ? iccm_rdata_i : '0;
    assign core_rst_o    = r_core_rst;
    assign iccm_csb_o    = r_csb;
    assign iccm_web_o    = r_web;
    assign iccm_addr_o   = r_addr;
    assign iccm_wdata_o  = r_wdata;
    assign word_cnt_o    = r_word_cnt;
    assign checksum_o    = r_checksum;
    assign ign_wr_o      = r_ign_wr;

endmodule
`default_nettype wire

// File: tb/tb_iccm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iccm_port_arbiter
// Brief    : Scoreboard bench for iccm_port_arbiter with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iccm_port_arbiter;

    localparam int c_RC   = 16;
    localparam int c_WDS  = 4096;
    localparam int M_RUN  = 0;
    localparam int M_LOAD = 1;
    localparam int M_REL  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [11:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic        prog_reset = 1'b0;
    logic        core_req = 1'b0;
    logic [11:0] core_addr = '0;
    logic        core_gnt, core_rvalid, core_rst;
    logic [31:0] core_rdata;
    logic        iccm_csb, iccm_web;
    logic [11:0] iccm_addr;
    logic [31:0] iccm_wdata;
    logic [31:0] sram_rdata = '0;
    logic [12:0] word_cnt;
    logic [31:0] checksum;
    logic        ign_wr;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    iccm_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata),
        .prog_reset_i(prog_reset),
        .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt),
        .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_rst_o(core_rst),
        .iccm_csb_o(iccm_csb), .iccm_web_o(iccm_web), .iccm_addr_o(iccm_addr),
        .iccm_wdata_o(iccm_wdata), .iccm_rdata_i(sram_rdata),
        .word_cnt_o(word_cnt), .checksum_o(checksum), .ign_wr_o(ign_wr)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM on the arbitrated port
    logic [31:0] sram [c_WDS];
    always @(posedge clk) begin
        if (!iccm_csb) begin
            if (!iccm_web) sram[iccm_addr] <= iccm_wdata;
            else           sram_rdata      <= sram[iccm_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [11:0] addr; logic [31:0] data; int due; } exp_t;
    exp_t        q_wr[$];
    exp_t        q_rd_port[$];
    exp_t        q_rd_data[$];
    logic [31:0] ref_mem [c_WDS];
    int          m_mode = M_REL;
    int          m_left = c_RC;
    int          m_cnt  = 0;
    logic [31:0] m_sum  = '0;
    bit          m_ign  = 1'b0;
    int          cyc    = 0;

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            m_mode = M_REL; m_left = c_RC; m_cnt = 0; m_sum = '0; m_ign = 1'b0;
        end else begin
            if (prog_we) begin
                if (m_mode == M_LOAD) begin
                    e.addr = prog_addr; e.data = prog_wdata; e.due = cyc;
                    q_wr.push_back(e);
                    ref_mem[prog_addr] = prog_wdata;
                    if (m_cnt < c_WDS) m_cnt++;
                    m_sum = m_sum + prog_wdata;
                end else begin
                    m_ign = 1'b1;
                end
            end
            if (m_mode == M_RUN && core_req) begin
                e.addr = core_addr; e.data = ref_mem[core_addr]; e.due = cyc;
                q_rd_port.push_back(e);
                e.due = cyc + 1;
                q_rd_data.push_back(e);
            end
            if (m_mode == M_LOAD) begin
                if (!prog_reset) begin m_mode = M_REL; m_left = c_RC; end
            end else if (prog_reset) begin
                m_mode = M_LOAD; m_cnt = 0; m_sum = '0;
            end else if (m_mode == M_REL) begin
                m_left--;
                if (m_left == 0) m_mode = M_RUN;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (!iccm_csb && !iccm_web) begin
                if (q_wr.size() == 0) chk("sram_wr_unexpected", {31'd0, iccm_csb}, 64'd1);
                else begin
                    e = q_wr.pop_front();
                    chk("sram_wr_addr", iccm_addr, e.addr);
                    chk("sram_wr_data", iccm_wdata, e.data);
                    chk("sram_wr_cycle", cyc, e.due);
                end
            end else if (!iccm_csb) begin
                if (q_rd_port.size() == 0) chk("sram_rd_unexpected", {31'd0, iccm_csb}, 64'd1);
                else begin
                    e = q_rd_port.pop_front();
                    chk("sram_rd_addr", iccm_addr, e.addr);
                    chk("sram_rd_cycle", cyc, e.due);
                end
            end
            if (core_rvalid) begin
                if (q_rd_data.size() == 0) chk("rvalid_unexpected", {63'd0, core_rvalid}, 64'd0);
                else begin
                    e = q_rd_data.pop_front();
                    chk("core_rdata", core_rdata, e.data);
                    chk("core_rvalid_cycle", cyc, e.due);
                end
            end
            if (q_wr.size() != 0 && q_wr[0].due < cyc) begin
                chk("sram_wr_missed", q_wr[0].due, cyc);
                void'(q_wr.pop_front());
            end
            if (q_rd_data.size() != 0 && q_rd_data[0].due < cyc) begin
                chk("rvalid_missed", q_rd_data[0].due, cyc);
                void'(q_rd_data.pop_front());
            end
            chk("core_rst", core_rst, m_mode != M_RUN);
            chk("core_gnt", core_gnt, core_req && (m_mode == M_RUN));
            chk("word_cnt", word_cnt, m_cnt);
            chk("checksum", checksum, m_sum);
            chk("ign_wr", ign_wr, m_ign);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_rst_cycles(output int n);
        n = 0;
        while (core_rst && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < c_WDS; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end

        // 1: reset values and release window
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_csb", iccm_csb, 1);
        chk("rst_web", iccm_web, 1);
        chk("rst_addr", iccm_addr, 0);
        chk("rst_wdata", iccm_wdata, 0);
        chk("rst_rvalid", core_rvalid, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_ign_wr", ign_wr, 0);
        count_rst_cycles(n);
        chk("rst_release_len", n, 16);

        // 2: three-word load
        prog_reset = 1'b1;
        step();
        prog_we = 1'b1;
        prog_addr = 12'd0; prog_wdata = 32'h11;       step();
        prog_addr = 12'd1; prog_wdata = 32'h22;       step();
        prog_addr = 12'd2; prog_wdata = 32'hFFFFFFFF; step();
        prog_we = 1'b0;
        step();
        chk("load_word_cnt", word_cnt, 3);
        chk("load_checksum", checksum, 32'h32);

        // 3: release then fetch
        prog_reset = 1'b0;
        step();
        count_rst_cycles(n);
        chk("load_release_len", n, 16);
        core_req = 1'b1; core_addr = 12'd1;
        #1;
        chk("fetch_gnt", core_gnt, 1);
        step();
        core_req = 1'b0;
        step();
        chk("fetch_rvalid", core_rvalid, 1);
        chk("fetch_rdata", core_rdata, 32'h22);

        // 4: stray write in RUN
        prog_we = 1'b1; prog_addr = 12'd5; prog_wdata = 32'hDEAD;
        step();
        prog_we = 1'b0;
        step();
        chk("stray_ign", ign_wr, 1);
        chk("stray_cnt", word_cnt, 3);
        chk("stray_sum", checksum, 32'h32);

        // 5: fetch coinciding with load start
        core_req = 1'b1; core_addr = 12'd2; prog_reset = 1'b1;
        #1;
        chk("coll_gnt", core_gnt, 1);
        step();
        core_addr = 12'd0;
        #1;
        chk("coll_next_gnt", core_gnt, 0);
        chk("coll_core_rst", core_rst, 1);
        step();
        core_req = 1'b0;
        chk("coll_rvalid", core_rvalid, 1);
        chk("coll_rdata", core_rdata, 32'hFFFFFFFF);
        chk("coll_cnt_clear", word_cnt, 0);

        // 6: restart during RELEASE
        prog_we = 1'b1;
        prog_addr = 12'd3; prog_wdata = 32'h5; step();
        prog_addr = 12'd4; prog_wdata = 32'h6; step();
        prog_we = 1'b0; prog_reset = 1'b0;
        step(); step(); step();
        chk("restart_cnt_kept", word_cnt, 2);
        prog_reset = 1'b1;
        step();
        chk("restart_cnt", word_cnt, 0);
        chk("restart_core_rst", core_rst, 1);

        // rst in the middle of a load drops the in-flight write
        prog_we = 1'b1; prog_addr = 12'd7; prog_wdata = 32'h77; step();
        rst = 1'b1; prog_addr = 12'd8; prog_wdata = 32'h88; step();
        rst = 1'b0; prog_we = 1'b0;
        chk("midrst_csb", iccm_csb, 1);
        chk("midrst_cnt", word_cnt, 0);
        step();

        // word count saturation
        prog_we = 1'b1;
        for (int i = 0; i < 4100; i++) begin
            prog_addr = 12'($urandom_range(0, 4095));
            prog_wdata = $urandom;
            step();
        end
        prog_we = 1'b0;
        step();
        chk("sat_word_cnt", word_cnt, 13'h1000);

        // randomized mix of loads, restarts, stray writes and fetches
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) prog_reset = ~prog_reset;
            prog_we    = ($urandom_range(0, 2) == 0);
            prog_addr  = 12'($urandom_range(0, 31));
            prog_wdata = $urandom;
            core_req   = ($urandom_range(0, 1) == 0);
            core_addr  = 12'($urandom_range(0, 31));
            step();
        end
        prog_reset = 1'b0; prog_we = 1'b0; core_req = 1'b0;
        n = 0;
        while (core_rst && n < 100) begin step(); n++; end
        chk("final_run_reached", core_rst, 0);
        for (int i = 0; i < 60; i++) begin
            core_req  = ($urandom_range(0, 3) != 0);
            core_addr = 12'($urandom_range(0, 31));
            step();
        end
        core_req = 1'b0;
        step(); step(); step();
        chk("q_wr_empty", q_wr.size(), 0);
        chk("q_rd_port_empty", q_rd_port.size(), 0);
        chk("q_rd_data_empty", q_rd_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
